// File: rtl/spi_pkg.sv
// Shared types and constants for the arbitrated SPI master (mode CPOL=1, CPHA=0).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    GAP
  } spi_state_t;

  localparam logic SPI_CPOL       = 1'b1;
  localparam logic SPI_CPHA       = 1'b0;
  localparam int   SPI_FRAME_BITS = 8;

  // Counter width for a count range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] request,
  input  logic       update,
  output logic [1:0] winner
);

  logic last_one;  // requester 1 was granted last

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner = 2'b00;
    case (request)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_one ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

  // Reset value makes requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      last_one <= 1'b1;
    end else if (update && (winner != 2'b00)) begin
      last_one <= winner[1];
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// SPI master (CPOL=1, CPHA=0, LSB first) shared by two requesters via round-robin.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  output logic [1:0] o_grant,
  output logic [1:0] o_done,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_select,
  output logic       o_busy
);

  localparam int CNT_W = cnt_width((CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES);
  localparam int BIT_W = $clog2(SPI_FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(SPI_FRAME_BITS);

  spi_state_t                state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [1:0]                owner;
  logic [1:0]                win;
  logic [7:0]                cap;
  logic                      start;
  logic                      tick;
  logic                      advance;

  spi_rr_arbiter u_arb (
    .clk     (i_clock),
    .rst     (i_reset),
    .request (i_req),
    .update  (start),
    .winner  (win)
  );

  assign start = (state == IDLE) && (i_req != 2'b00);
  assign tick  = (cnt == '0);
  assign cap   = win[1] ? i_data1 : i_data0;
  // With CPHA=0 the next bit launches on the edge that leaves LOW.
  assign advance = (state == LOW) && tick && (SPI_CPHA == 1'b0);

  always_comb begin
    state_next = state;
    o_sclk     = SPI_CPOL;
    o_select   = 1'b1;
    o_busy     = (state != IDLE);
    case (state)
      IDLE:    if (i_req != 2'b00) state_next = SETUP;
      SETUP: begin
        o_select = 1'b0;
        if (tick) state_next = LOW;
      end
      LOW: begin
        o_select = 1'b0;
        o_sclk   = ~SPI_CPOL;
        if (tick) state_next = HIGH;
      end
      HIGH: begin
        o_select = 1'b0;
        if (tick) state_next = (bit_cnt == ALL_BITS) ? GAP : LOW;
      end
      GAP:     if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      owner   <= 2'b00;
      o_mosi  <= 1'b1;
      o_grant <= 2'b00;
      o_done  <= 2'b00;
    end else begin
      state   <= state_next;
      o_grant <= 2'b00;
      o_done  <= 2'b00;

      // Divider reloads on every state change and counts down to terminal zero.
      if (state_next != state) begin
        cnt <= (state_next == GAP) ? GAP_LOAD : DIV_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (start) begin
        o_grant <= win;
        owner   <= win;
        shreg   <= cap;
        o_mosi  <= cap[0];
        bit_cnt <= '0;
      end

      // Count falling SCLK edges; each one is a bit sampled by the slave.
      if ((state_next == LOW) && (state != LOW)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Arithmetic shift keeps the last bit on MOSI after the final advance.
      if (advance) begin
        shreg  <= {shreg[SPI_FRAME_BITS-1], shreg[SPI_FRAME_BITS-1:1]};
        o_mosi <= shreg[1];
      end

      if ((state == HIGH) && tick && (bit_cnt == ALL_BITS)) begin
        o_done <= owner;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench: three instances (CLK_DIV 2, 1, 5) checked by per-instance SPI receiver monitors.
module tb_spi_master_arb;

  localparam int GAP = 2;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_v   [3];
  logic [1:0] req_v   [3];
  logic [7:0] d0_v    [3];
  logic [7:0] d1_v    [3];
  logic [1:0] grant_v [3];
  logic [1:0] done_v  [3];
  logic       sclk_v  [3];
  logic       mosi_v  [3];
  logic       sel_v   [3];
  logic       busy_v  [3];

  frame_t     fq [3][$];
  logic [1:0] gq [3][$];
  bit         model_last [3];  // true when requester 1 was granted last
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  generate
    for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      spi_master_arb #(.CLK_DIV(DIV), .GAP_CYCLES(GAP)) u_dut (
        .i_clock  (clk),
        .i_reset  (rst_v[g]),
        .i_req    (req_v[g]),
        .i_data0  (d0_v[g]),
        .i_data1  (d1_v[g]),
        .o_grant  (grant_v[g]),
        .o_done   (done_v[g]),
        .o_sclk   (sclk_v[g]),
        .o_mosi   (mosi_v[g]),
        .o_select (sel_v[g]),
        .o_busy   (busy_v[g])
      );

      // Receiver: samples MOSI at each falling SCLK while select is low.
      initial begin
        logic       ps, pl, pm, frame_end;
        logic [7:0] rx;
        int         nb, lowc, highc;
        bit         seen;
        frame_t     f;
        ps = 1'b1; pl = 1'b1; pm = 1'b1; rx = '0;
        nb = 0; lowc = 0; highc = 0; seen = 1'b0;
        forever begin
          @(negedge clk);
          if (rst_v[g]) begin
            ps = 1'b1; pl = 1'b1; nb = 0; lowc = 0; highc = 0; seen = 1'b0;
            continue;
          end
          if (grant_v[g] != 2'b00) begin
            check("grant_expected", 32'(gq[g].size() > 0), 1);
            if (gq[g].size() > 0) check("grant", grant_v[g], gq[g].pop_front());
          end
          frame_end = !pl && sel_v[g];
          if ((done_v[g] != 2'b00) && !frame_end) check("spurious_done", done_v[g], 0);
          if (pl && !sel_v[g]) begin
            if (seen) check("gap_high_cycles_ok", 32'(highc >= GAP), 1);
            rx = '0; nb = 0; lowc = 0;
          end
          if (!sel_v[g]) begin
            lowc++;
            if (ps && !sclk_v[g]) begin
              if (nb < 8) rx[nb] = mosi_v[g];
              nb++;
            end else if (!ps && !sclk_v[g] && (mosi_v[g] !== pm)) begin
              check("mosi_stable_while_low", mosi_v[g], pm);
            end
          end
          if (frame_end) begin
            check("frame_expected", 32'(fq[g].size() > 0), 1);
            if (fq[g].size() > 0) begin
              f = fq[g].pop_front();
              check("rx_byte", rx, f.data);
              check("rx_bits", nb, 8);
              check("select_low_cycles", lowc, 17 * DIV);
              check("done", done_v[g], f.owner);
            end
            seen  = 1'b1;
            highc = 0;
          end
          if (sel_v[g]) highc++;
          ps = sclk_v[g]; pl = sel_v[g]; pm = mosi_v[g];
        end
      end
    end
  endgenerate

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int g);
    int k = 0;
    while (busy_v[g] && (k < 2000)) begin
      tick_n(1);
      k++;
    end
    if (busy_v[g]) check("idle_timeout", busy_v[g], 0);
  endtask

  // Reference arbitration: a lone request wins, a tie goes to the one not served last.
  function automatic logic [1:0] pick(input int g, input logic [1:0] p);
    if (p == 2'b11) return model_last[g] ? 2'b01 : 2'b10;
    return p;
  endfunction

  task automatic expect_frame(input int g, input logic [1:0] w);
    frame_t f;
    f.owner = w;
    f.data  = (w == 2'b01) ? d0_v[g] : d1_v[g];
    fq[g].push_back(f);
    gq[g].push_back(w);
    model_last[g] = (w == 2'b10);
  endtask

  task automatic random_round(input bit allow_new, inout logic [1:0] pending);
    logic [1:0] nb, w, pbit;
    wait_idle(0);
    nb = allow_new ? 2'($urandom_range(0, 3)) : 2'b00;
    if (allow_new && ((pending | nb) == 2'b00)) nb = 2'($urandom_range(1, 3));
    if (nb[0] && !pending[0]) d0_v[0] = 8'($urandom);
    if (nb[1] && !pending[1]) d1_v[0] = 8'($urandom);
    pending   = pending | nb;
    req_v[0]  = pending;
    w         = pick(0, pending);
    expect_frame(0, w);
    tick_n(1);
    pending  = pending & ~w;
    req_v[0] = pending;
    if (w == 2'b01) d0_v[0] = 8'($urandom);
    else            d1_v[0] = 8'($urandom);
    // A one-cycle request while busy must vanish without a grant.
    if (($urandom_range(0, 1) == 1) && (pending != 2'b11)) begin
      pbit = (pending == 2'b00) ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10) : (~pending & 2'b11);
      tick_n($urandom_range(1, 20));
      req_v[0] = pending | pbit;
      tick_n(1);
      req_v[0] = pending;
    end
  endtask

  task automatic run_main();
    int         cnt, falls, k;
    logic       prev;
    logic [1:0] pending;

    // Tie right after reset: 0, 1, 0 while both requests stay high.
    d0_v[0] = 8'h3C; d1_v[0] = 8'hC3;
    req_v[0] = 2'b11;
    for (int i = 0; i < 3; i++) expect_frame(0, pick(0, 2'b11));
    cnt = 0; k = 0;
    while ((cnt < 3) && (k < 3000)) begin
      tick_n(1);
      if (grant_v[0] != 2'b00) cnt++;
      k++;
    end
    req_v[0] = 2'b00;
    check("tie_grants_seen", cnt, 3);

    wait_idle(0);
    d0_v[0] = 8'hA5; req_v[0] = 2'b01;
    expect_frame(0, 2'b01);
    tick_n(1);
    req_v[0] = 2'b00;

    pending = 2'b00;
    for (int r = 0; r < 30; r++) random_round(1'b1, pending);
    while (pending != 2'b00) random_round(1'b0, pending);

    // Abort a frame after its third falling SCLK edge.
    wait_idle(0);
    d0_v[0] = 8'h55; req_v[0] = 2'b01;
    expect_frame(0, 2'b01);
    tick_n(1);
    req_v[0] = 2'b00;
    falls = 0; prev = sclk_v[0]; k = 0;
    while ((falls < 3) && (k < 500)) begin
      tick_n(1);
      if (prev && !sclk_v[0]) falls++;
      prev = sclk_v[0];
      k++;
    end
    check("falls_before_reset", falls, 3);
    #2;
    rst_v[0] = 1'b1;
    #1;
    check("abort_sclk", sclk_v[0], 1);
    check("abort_select", sel_v[0], 1);
    check("abort_busy", busy_v[0], 0);
    check("abort_mosi", mosi_v[0], 1);
    fq[0].delete();
    gq[0].delete();
    model_last[0] = 1'b1;
    tick_n(3);
    rst_v[0] = 1'b0;

    d0_v[0] = 8'hFF; req_v[0] = 2'b01;
    expect_frame(0, 2'b01);
    tick_n(1);
    req_v[0] = 2'b00;
    wait_idle(0);
  endtask

  task automatic run_sweep(input int g);
    tick_n(1);
    d0_v[g] = 8'h01; req_v[g] = 2'b01;
    expect_frame(g, 2'b01);
    tick_n(1);
    req_v[g] = 2'b00;
    wait_idle(g);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_v[g] = 1'b1; req_v[g] = 2'b00; d0_v[g] = '0; d1_v[g] = '0;
      model_last[g] = 1'b1;
    end
    tick_n(2);
    for (int g = 0; g < 3; g++) begin
      check("rst_sclk", sclk_v[g], 1);
      check("rst_select", sel_v[g], 1);
      check("rst_mosi", mosi_v[g], 1);
      check("rst_grant", grant_v[g], 0);
      check("rst_done", done_v[g], 0);
      check("rst_busy", busy_v[g], 0);
    end
    // Requests are already high while reset is still asserted.
    req_v[1] = 2'b01;
    tick_n(1);
    check("no_grant_in_reset", grant_v[1], 0);
    req_v[1] = 2'b00;
    for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;

    fork
      run_main();
      run_sweep(1);
      run_sweep(2);
    join

    tick_n(20);
    for (int g = 0; g < 3; g++) begin
      check("frames_left", fq[g].size(), 0);
      check("grants_left", gq[g].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
